pipelined_adder_arbiter: RTL and testbench
==========================================

# pipelined_adder_arbiter

Round-robin scheduler sharing one `fully_pipelined_adder` instance between `NREQ` requesters. Each requester presents an operand pair plus carry-in with a valid/ready handshake. The block issues at most one operation per cycle into the adder and tracks each in-flight operation with a requester tag through a shadow pipeline. It returns each result on a shared response port tagged with the originating requester, and stalls the adder when the response consumer applies backpressure.

## Interface
- `WIDTH`, 3: operand/sum width of the adder.
- `LAT`, `WIDTH`: adder latency in enabled edges, from the edge that samples `add_a/b/c` to the edge after which `add_s/add_carry` show that result.
- `NREQ`, 4: number of requesters, ≥2.
- `IDW`, `$clog2(NREQ)`: tag width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester operation valid.
- `req_a`  in  NREQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing.
- `req_c`  in  NREQ  carry-in.
- `req_ready`  out  NREQ  one-hot-or-zero grant; handshake = valid & ready at an edge.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  requester index of result.
- `rsp_sum`  out  WIDTH  sum.
- `rsp_carry`  out  1  carry-out.
- `busy`  out  1  any operation in operand register or tag pipe.
- `add_a`, `add_b`  out  WIDTH  to adder `a`, `b`.
- `add_c`  out  1  to adder `c`.
- `add_en`  out  1  to adder `en`.
- `add_s`  in  WIDTH  from adder `s`.
- `add_carry`  in  1  from adder `carry`.

## Operation
- Stall: `add_en = ~(rsp_valid & ~rsp_ready)`. When `add_en`=0, operand register, tag pipe, RR pointer and adder all hold; `req_ready` = 0.
- Arbitration: round-robin pointer `ptr`. Winner = first i with `req_valid[i]`, searching `ptr, ptr+1, …, NREQ-1, 0, …` (modulo `NREQ`). `req_ready[winner] = add_en`; all other bits are 0. `req_ready` may depend combinationally on `req_valid`.
- On a handshake with requester g:
  - `ptr <= (g+1) mod NREQ`.
  - Operand register loads `req_a/b/c[g]`; stage-0 tag loads {valid=1, id=g}.
- With no handshake on an enabled edge: stage-0 valid <= 0 (bubble). Operand data is don't-care.
- Tag pipe: `LAT` stages {valid, id}, advancing only on `add_en` edges in lockstep with the adder.
- Outputs:
  - `rsp_valid` = last-stage valid; `rsp_id` = last-stage id.
  - `rsp_sum`/`rsp_carry` = `add_s`/`add_carry` when `rsp_valid`, else 0.
- Arithmetic: {`rsp_carry`,`rsp_sum`} = a + b + c (WIDTH+1 bits, no truncation beyond carry).
- Responses leave in issue order; no reordering, drop or duplication.
- `busy` = OR of stage-0 valid and all tag-pipe valids.

## Timing
- Reset (`rst`=0, asynchronous): all tag valids 0, `ptr`=0, operand register 0. Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_carry`=0, `busy`=0, `add_a/b/c`=0, `add_en`=1.
- Deassert `rst` synchronously to `clk` externally. First arbitration occurs on the first edge after release.
- Latency: handshake at edge k, no stalls, gives `rsp_valid` high from edge k+1+LAT-1 = k+LAT. The result is consumed at edge k+LAT+1 if `rsp_ready`=1.
- Throughput: one issue and one response per cycle sustained.
- Backpressure: while `rsp_valid & ~rsp_ready`, `rsp_*` are stable and `req_ready`=0. The cycle `rsp_ready` rises, the stall releases on that edge.
- Same-cycle handshake and response acceptance are both permitted.
- Reset mid-operation: all in-flight operations are discarded and no response is produced for them. The adder's internal state is irrelevant because the tags are cleared.
- `req_valid` deassert without a handshake is legal (no commitment).

## Test plan
- WIDTH=3, LAT=3, NREQ=4, `rsp_ready`=1; req0 a=4 b=2 c=1 handshakes at edge k -> `rsp_valid` high after edge k+3, `rsp_id`=0, `rsp_sum`=7, `rsp_carry`=0, `busy` 0 after consumption.
- req2 a=7 b=7 c=1 -> `rsp_id`=2, `rsp_sum`=7, `rsp_carry`=1. Sequential 4+3+1 -> sum 0, carry 1.
- All four requesters held valid with distinct operands for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive edges; responses in the same id order, one per cycle, each sum correct.
- Back-to-back traffic, `rsp_ready` low for 2 cycles while `rsp_valid`=1 -> `add_en`=0, `req_ready`=0, `rsp_*` constant. Sequence resumes with no loss or duplicate.
- Only req1 and req3 valid, `ptr`=2 -> grant 3, then 1, then 3. Req1 drops valid before grant -> no response for req1.
- Three operations in flight, `rst` pulsed low mid-cycle -> `rsp_valid`, `busy`, `req_ready` drop immediately. After release with req0 and req2 valid -> first grant to req0; no stale responses.

Source files
------------

// File: rtl/pipelined_adder_arbiter.sv
// Round-robin front end that shares one external, fully pipelined adder
// between NREQ requesters. Each accepted operation carries its requester
// index through a tag pipe that runs in lockstep with the adder. Results
// come back in issue order on a single response port. Response
// backpressure freezes the operand register, the tags, the pointer and the adder.
module pipelined_adder_arbiter #(
  parameter int WIDTH = 3,
  parameter int LAT   = WIDTH,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_c,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry,
  output logic                    busy,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_c,
  output logic                    add_en,
  input  logic [WIDTH-1:0]        add_s,
  input  logic                    add_carry
);

  // Round-robin pointer and arbitration result
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW:0]     cand;
  logic             fire;

  // Operand register feeding the adder, plus the stage-0 tag that rides with it
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_c_q;
  logic             s0_valid_q;
  logic [IDW-1:0]   s0_id_q;

  // Tag pipe: one {valid, id} entry per adder stage
  logic [LAT-1:0]   pipe_valid_q;
  logic [LAT-1:0]   pipe_valid_d;
  logic [IDW-1:0]   pipe_id_q [LAT];
  logic [IDW-1:0]   pipe_id_d [LAT];

  genvar gi;

  // A result waiting on a stalled consumer freezes everything upstream
  assign add_en = ~(rsp_valid & ~rsp_ready);

  // Rotating priority search: first valid requester at or after ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    // Walk from the farthest offset down so the nearest valid one wins
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  // Grants are withheld during reset and while the pipe is frozen
  assign fire  = add_en & win_found & rst;
  assign ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = fire & (win_id == IDW'(gi));
    end
  endgenerate

  // Capture the winner's operands and tag; an idle enabled edge inserts a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_id_q    <= '0;
    end else if (add_en) begin
      s0_valid_q <= fire;
      if (fire) begin
        ptr_q   <= ptr_d;
        op_a_q  <= req_a[win_id*WIDTH +: WIDTH];
        op_b_q  <= req_b[win_id*WIDTH +: WIDTH];
        op_c_q  <= req_c[win_id];
        s0_id_q <= win_id;
      end
    end
  end

  // Next-state of each tag stage is simply the previous stage's contents
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        assign pipe_valid_d[gi] = s0_valid_q;
        assign pipe_id_d[gi]    = s0_id_q;
      end else begin : g_rest
        assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
        assign pipe_id_d[gi]    = pipe_id_q[gi-1];
      end
    end
  endgenerate

  // Advance the tag pipe only on edges where the adder advances too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_id_q[i] <= '0;
      end
    end else if (add_en) begin
      pipe_valid_q <= pipe_valid_d;
      pipe_id_q    <= pipe_id_d;
    end
  end

  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign add_c     = op_c_q;

  assign rsp_valid = pipe_valid_q[LAT-1];
  assign rsp_id    = pipe_id_q[LAT-1];
  // Adder output is only meaningful when the matching tag is valid
  assign rsp_sum   = rsp_valid ? add_s : '0;
  assign rsp_carry = rsp_valid & add_carry;

  assign busy      = s0_valid_q | (|pipe_valid_q);

endmodule

// File: tb/tb_pipelined_adder_arbiter.sv
// Directed bench for pipelined_adder_arbiter with a behavioural LAT-stage
// adder. A negedge monitor logs every grant and every accepted response;
// each scenario compares those logs against hand-computed tables.
module tb_pipelined_adder_arbiter;
  localparam int WIDTH = 3;
  localparam int LAT   = 3;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_c;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic                  busy;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_c;
  logic                  add_en;
  logic [WIDTH-1:0]      add_s;
  logic                  add_carry;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int grant_q[$];
  int grant_cyc[$];
  int rsp_q[$];
  int rsp_cyc[$];
  int exp_q[$];

  pipelined_adder_arbiter #(
    .WIDTH(WIDTH), .LAT(LAT), .NREQ(NREQ), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_en(add_en),
    .add_s(add_s), .add_carry(add_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: LAT enabled edges from operand sample to visible result
  logic [WIDTH:0] adder_pipe [LAT];
  always @(posedge clk) begin
    if (add_en) begin
      adder_pipe[0] <= (WIDTH+1)'(add_a) + (WIDTH+1)'(add_b) + (WIDTH+1)'(add_c);
      for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
  end
  assign add_s     = adder_pipe[LAT-1][WIDTH-1:0];
  assign add_carry = adder_pipe[LAT-1][WIDTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are stable between posedge+1 and the next posedge, so negedge
  // sees exactly what the coming edge will see
  always @(negedge clk) begin
    check_eq("onehot_ready", ($countones(req_ready) > 1), 0);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        grant_q.push_back(i);
        grant_cyc.push_back(cyc);
        $display("cyc %0d grant id=%0d", cyc, i);
      end
    end
    if (rsp_valid && rsp_ready) begin
      rsp_q.push_back(int'(rsp_id) * 16 + int'(rsp_carry) * 8 + int'(rsp_sum));
      rsp_cyc.push_back(cyc);
      $display("cyc %0d rsp id=%0d carry=%0d sum=%0d", cyc, rsp_id, rsp_carry, rsp_sum);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c);
    req_a[i*WIDTH +: WIDTH] = a[WIDTH-1:0];
    req_b[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
    req_c[i]                = c[0];
  endtask

  task automatic clear_logs();
    grant_q.delete();
    grant_cyc.delete();
    rsp_q.delete();
    rsp_cyc.delete();
  endtask

  // exp_q entries are id*16 + carry*8 + sum; grant order equals response order
  task automatic check_seq(input string tag, input bit consec);
    int n;
    n = exp_q.size();
    check_eq({tag, "_ngrant"}, grant_q.size(), n);
    check_eq({tag, "_nrsp"}, rsp_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < grant_q.size()) check_eq($sformatf("%s_grant%0d", tag, i), grant_q[i], exp_q[i] / 16);
      if (i < rsp_q.size())   check_eq($sformatf("%s_rsp%0d", tag, i), rsp_q[i], exp_q[i]);
      if (consec && i > 0 && i < rsp_q.size())
        check_eq($sformatf("%s_rspgap%0d", tag, i), rsp_cyc[i] - rsp_cyc[i-1], 1);
      if (consec && i > 0 && i < grant_q.size())
        check_eq($sformatf("%s_grantgap%0d", tag, i), grant_cyc[i] - grant_cyc[i-1], 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests asserted to show grants stay off
    #2;
    req_valid = 4'b1111;
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_add_en", add_en, 1);
    check_eq("rst_add_abc", {add_a, add_b, add_c}, 0);
    check_eq("rst_rsp", {rsp_id, rsp_carry, rsp_sum}, 0);
    step();
    step();
    check_eq("rst_busy_hold", busy, 0);
    check_eq("rst_ready_hold", req_ready, 0);
    req_valid = '0;
    rst = 1'b1;
    step();

    // Single op: 4+2+1 = 7 from req0, result visible LAT edges after handshake
    set_op(0, 4, 2, 1);
    req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    #1;
    check_eq("t1_busy", busy, 1);
    check_eq("t1_add_a", add_a, 4);
    step();
    check_eq("t1_v_k1", rsp_valid, 0);
    step();
    check_eq("t1_v_k2", rsp_valid, 0);
    step();
    check_eq("t1_v_k3", rsp_valid, 1);
    check_eq("t1_id", rsp_id, 0);
    check_eq("t1_sum", rsp_sum, 7);
    check_eq("t1_carry", rsp_carry, 0);
    step();
    check_eq("t1_v_done", rsp_valid, 0);
    check_eq("t1_busy_done", busy, 0);
    check_eq("t1_sum_idle", rsp_sum, 0);

    // ptr=1: req2 (7+7+1=15) then req3 (4+3+1=8)
    clear_logs();
    set_op(2, 7, 7, 1);
    set_op(3, 4, 3, 1);
    req_valid = 4'b1100;
    #1;
    check_eq("t2_ready0", req_ready, 4'b0100);
    step();
    check_eq("t2_ready1", req_ready, 4'b1000);
    step();
    req_valid = '0;
    repeat (5) step();
    exp_q = '{47, 56};
    check_seq("t2", 1'b0);

    // All four valid for 8 edges: 0,1,2,3,0,1,2,3 back to back
    clear_logs();
    set_op(0, 1, 2, 0);
    set_op(1, 3, 3, 1);
    set_op(2, 5, 6, 0);
    set_op(3, 7, 0, 1);
    req_valid = 4'b1111;
    repeat (8) step();
    req_valid = '0;
    repeat (5) step();
    exp_q = '{3, 23, 43, 56, 3, 23, 43, 56};
    check_seq("t3", 1'b1);

    // Backpressure for two cycles while the first result is presented
    clear_logs();
    req_valid = 4'b1111;
    repeat (4) step();
    check_eq("t4_first_valid", rsp_valid, 1);
    rsp_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check_eq($sformatf("t4_en_%0d", s), add_en, 0);
      check_eq($sformatf("t4_ready_%0d", s), req_ready, 0);
      check_eq($sformatf("t4_rsp_%0d", s), {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 2'd0, 1'b0, 3'd3});
      if (s < 2) step();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("t4_release_en", add_en, 1);
    check_eq("t4_release_ready", req_ready, 4'b0001);
    step();
    step();
    req_valid = '0;
    repeat (6) step();
    exp_q = '{3, 23, 43, 56, 3, 23};
    check_seq("t4", 1'b0);

    // ptr=2 with only req1/req3 valid: 3,1,3, then req1 withdraws ungranted
    clear_logs();
    set_op(1, 2, 1, 0);
    set_op(3, 6, 5, 1);
    req_valid = 4'b1010;
    #1;
    check_eq("t5_ready0", req_ready, 4'b1000);
    step();
    check_eq("t5_ready1", req_ready, 4'b0010);
    step();
    check_eq("t5_ready2", req_ready, 4'b1000);
    step();
    req_valid = '0;
    #1;
    check_eq("t5_ready_drop", req_ready, 0);
    repeat (5) step();
    exp_q = '{60, 19, 60};
    check_seq("t5", 1'b0);

    // Reset pulse with three ops in flight: nothing stale may emerge
    clear_logs();
    set_op(0, 1, 2, 0);
    set_op(1, 3, 3, 1);
    set_op(2, 5, 6, 0);
    req_valid = 4'b0111;
    repeat (3) step();
    req_valid = 4'b0101;
    #1;
    check_eq("t6_busy_pre", busy, 1);
    check_eq("t6_ready_pre", req_ready, 4'b0001);
    #1;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_valid", rsp_valid, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_ready", req_ready, 0);
    check_eq("t6_rst_en", add_en, 1);
    clear_logs();
    step();
    rst = 1'b1;
    #1;
    check_eq("t6_after_ready", req_ready, 4'b0001);
    step();
    step();
    req_valid = '0;
    repeat (5) step();
    exp_q = '{3, 43};
    check_seq("t6", 1'b0);
    check_eq("t6_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
